// File: rtl/encodehigh_if.sv
// Request/code bundle for encodehigh: request lines d0..d3, ready/valid
// handshake, 2-bit code {s0,s1}, overflow pulse and busy flag.
interface encodehigh_if;
  logic d0;
  logic d1;
  logic d2;
  logic d3;
  logic ready;
  logic valid;
  logic s0;
  logic s1;
  logic ovf;
  logic busy;

  modport master (
    output d0, d1, d2, d3, ready,
    input  valid, s0, s1, ovf, busy
  );

  modport slave (
    input  d0, d1, d2, d3, ready,
    output valid, s0, s1, ovf, busy
  );
endinterface

// File: rtl/encodehigh.sv
// Sequential 4-to-2 request encoder: queues requests on d0..d3 and emits codes
// over valid/ready. Define ROUND_ROBIN_EN for rotating priority (default: 3>2>1>0).
module encodehigh #(
  parameter int unsigned EDGE_MODE = 1
) (
  input  logic         clk,
  input  logic         rst,
  encodehigh_if.slave  bus
);

  logic [3:0] d_in;
  logic [3:0] dprev_q, dprev_d;
  logic [3:0] pend_q, pend_d;
  logic [3:0] req;
  logic [3:0] clr;
  logic [1:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;
  logic       busy_q, busy_d;
  logic [1:0] grant;
  logic       grant_vld;
  logic       free;

  assign d_in = {bus.d3, bus.d2, bus.d1, bus.d0};

  always_comb begin
    req = '0;
    if (EDGE_MODE != 0) req = d_in & ~dprev_q;
    else                req = d_in;
  end

`ifdef ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;
  logic [1:0] idx;

  // Search last-1, last-2, last-3, last; first hit wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_q - 2'(i);
      if (!grant_vld && pend_q[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end
`else
  always_comb begin
    grant     = '0;
    grant_vld = |pend_q;
    if      (pend_q[3]) grant = 2'd3;
    else if (pend_q[2]) grant = 2'd2;
    else if (pend_q[1]) grant = 2'd1;
    else                grant = 2'd0;
  end
`endif

  always_comb begin
    free = ~valid_q | bus.ready;
    clr  = '0;
    if (free && grant_vld) clr[grant] = 1'b1;

    // A new request on a bit being cleared re-arms it (set wins).
    pend_d  = (pend_q & ~clr) | req;
    ovf_d   = (EDGE_MODE != 0) ? |(req & pend_q & ~clr) : 1'b0;
    dprev_d = d_in;

    valid_d = valid_q;
    code_d  = code_q;
    if (free) begin
      valid_d = grant_vld;
      if (grant_vld) code_d = grant;
    end
    busy_d = (|pend_d) | valid_d;
  end

`ifdef ROUND_ROBIN_EN
  always_comb begin
    last_d = last_q;
    if (free && grant_vld) last_d = grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= '0;
    else     last_q <= last_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dprev_q <= '0;
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      dprev_q <= dprev_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.valid = valid_q;
  assign bus.s0    = code_q[1];
  assign bus.s1    = code_q[0];
  assign bus.ovf   = ovf_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_encodehigh.sv
// Bench for encodehigh: edge-mode and level-mode instances driven in parallel,
// checked against directed vectors and a per-cycle queue model.
module tb_encodehigh;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d_drv = '0;
  logic       rdy_drv = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  encodehigh_if ife ();
  encodehigh_if ifl ();

  assign ife.d0 = d_drv[0];
  assign ife.d1 = d_drv[1];
  assign ife.d2 = d_drv[2];
  assign ife.d3 = d_drv[3];
  assign ife.ready = rdy_drv;
  assign ifl.d0 = d_drv[0];
  assign ifl.d1 = d_drv[1];
  assign ifl.d2 = d_drv[2];
  assign ifl.d3 = d_drv[3];
  assign ifl.ready = rdy_drv;

  encodehigh #(.EDGE_MODE(1)) u_edge (.clk(clk), .rst(rst), .bus(ife));
  encodehigh #(.EDGE_MODE(0)) u_level (.clk(clk), .rst(rst), .bus(ifl));

  typedef struct {
    bit prev [4];
    bit pend [4];
    bit valid;
    int code;
    bit ovf;
  } mstate_t;

  mstate_t me, ml;

  typedef struct {
    logic [3:0] d;
    logic       rdy;
    logic       v;
    logic [1:0] code;
    logic       ovf;
    logic       busy;
  } vec_t;

  vec_t tbl [23];

  function automatic mstate_t mreset();
    mstate_t s;
    for (int k = 0; k < 4; k++) begin
      s.prev[k] = 1'b0;
      s.pend[k] = 1'b0;
    end
    s.valid = 1'b0;
    s.code  = 0;
    s.ovf   = 1'b0;
    return s;
  endfunction

  function automatic mstate_t mstep(mstate_t s, logic [3:0] d, logic rdy, bit edge_m);
    mstate_t n = s;
    bit free = !s.valid || rdy;
    int g = -1;
    bit req [4];
    for (int k = 0; k < 4; k++)
      req[k] = edge_m ? (d[k] && !s.prev[k]) : d[k];
    if (free)
      for (int k = 3; k >= 0; k--)
        if (s.pend[k] && g < 0) g = k;
    n.ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (edge_m && req[k] && s.pend[k] && k != g) n.ovf = 1'b1;
      n.pend[k] = (s.pend[k] && k != g) || req[k];
      n.prev[k] = d[k];
    end
    if (free) begin
      n.valid = (g >= 0);
      if (g >= 0) n.code = g;
    end
    return n;
  endfunction

  function automatic bit mbusy(mstate_t s);
    bit b = s.valid;
    for (int k = 0; k < 4; k++) b = b | s.pend[k];
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input mstate_t m, input logic v,
                         input logic s0, input logic s1, input logic o, input logic b);
    check({tag, ".valid"}, 32'(v), 32'(m.valid));
    check({tag, ".ovf"}, 32'(o), 32'(m.ovf));
    check({tag, ".busy"}, 32'(b), 32'(mbusy(m)));
    if (m.valid) check({tag, ".code"}, 32'({s0, s1}), 32'(m.code));
  endtask

  task automatic cycle(input logic [3:0] d, input logic r);
    @(negedge clk);
    d_drv   = d;
    rdy_drv = r;
    @(posedge clk);
    #1;
    me = mstep(me, d, r, 1'b1);
    ml = mstep(ml, d, r, 1'b0);
    compare("model_edge", me, ife.valid, ife.s0, ife.s1, ife.ovf, ife.busy);
    compare("model_level", ml, ifl.valid, ifl.s0, ifl.s1, ifl.ovf, ifl.busy);
  endtask

  initial begin
    me = mreset();
    ml = mreset();

    tbl[0]  = '{4'b0010, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[1]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[2]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1};
    tbl[5]  = '{4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[6]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[7]  = '{4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[9]  = '{4'b0110, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[10] = '{4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[11] = '{4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[12] = '{4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[13] = '{4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[14] = '{4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[15] = '{4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[16] = '{4'b0001, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[17] = '{4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[18] = '{4'b0001, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1};
    tbl[19] = '{4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[20] = '{4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[21] = '{4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[22] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.edge.valid", 32'(ife.valid), 0);
    check("rst.edge.code", 32'({ife.s0, ife.s1}), 0);
    check("rst.edge.ovf", 32'(ife.ovf), 0);
    check("rst.edge.busy", 32'(ife.busy), 0);
    check("rst.level.valid", 32'(ifl.valid), 0);
    check("rst.level.busy", 32'(ifl.busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors on the edge-mode instance
    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].d, tbl[i].rdy);
      check($sformatf("vec%0d.valid", i), 32'(ife.valid), 32'(tbl[i].v));
      check($sformatf("vec%0d.ovf", i), 32'(ife.ovf), 32'(tbl[i].ovf));
      check($sformatf("vec%0d.busy", i), 32'(ife.busy), 32'(tbl[i].busy));
      if (tbl[i].v)
        check($sformatf("vec%0d.code", i), 32'({ife.s0, ife.s1}), 32'(tbl[i].code));
    end

    // Level mode: d2 held high repeats code 2 every cycle, never ovf
    cycle(4'b0100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0100, 1'b1);
      check("level.valid", 32'(ifl.valid), 1);
      check("level.code", 32'({ifl.s0, ifl.s1}), 2);
      check("level.ovf", 32'(ifl.ovf), 0);
    end
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // Async reset mid-stream with code 2 held and pend=1010
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b1010, 1'b0);
    check("pre_rst.valid", 32'(ife.valid), 1);
    check("pre_rst.code", 32'({ife.s0, ife.s1}), 2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.valid", 32'(ife.valid), 0);
    check("async_rst.code", 32'({ife.s0, ife.s1}), 0);
    check("async_rst.busy", 32'(ife.busy), 0);
    check("async_rst.ovf", 32'(ife.ovf), 0);
    check("async_rst.level_valid", 32'(ifl.valid), 0);
    d_drv = '0;
    me = mreset();
    ml = mreset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0000, 1'b1);
      check("post_rst.valid", 32'(ife.valid), 0);
      check("post_rst.busy", 32'(ife.busy), 0);
    end

    // Random stimulus against the model
    for (int i = 0; i < 500; i++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
